// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - boot loader: length-prefixed UART frame to 32-bit memory writes
// Optional macro UART_LOADER_CHECKSUM_EN adds a trailing mod-256 payload checksum byte.
module uart_loader #(
  parameter int                    ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ok,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERROR
`ifdef UART_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  // State entered once the payload is exhausted: checksum byte or straight to done.
`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [31:0]           len_q;
  logic [31:0]           asm_q;
  logic [1:0]            byte_idx_q;
  logic [ADDR_WIDTH:0]   word_idx_q;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic        start_ok;
  logic        byte_last;
  logic        word_last;
  logic        len_too_big;
  logic [31:0] len_full;
  logic [31:0] word_full;

  // Bytes arrive LSB first, so shifting right leaves the first byte in [7:0].
  assign len_full    = {rx_data, len_q[31:8]};
  assign word_full   = {rx_data, asm_q[31:8]};
  assign byte_last   = (byte_idx_q == 2'd3);
  assign word_last   = (33'(word_idx_q) + 33'd1) == 33'(len_q);
  assign len_too_big = 33'(len_full) > (33'd1 << ADDR_WIDTH);
  assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

  assign busy  = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef UART_LOADER_CHECKSUM_EN
                 || (state_q == S_CSUM)
`endif
                 ;
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_ERROR);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; rx_ok outside LEN/DATA/CSUM and start while busy are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_ok && byte_last) begin
          if (len_full == 32'd0) state_d = S_FINISH;
          else if (len_too_big)  state_d = S_ERROR;
          else                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_ok && byte_last && word_last) state_d = S_FINISH;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_ok) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: length/word assembly, indices, checksum and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      asm_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        len_q      <= '0;
        asm_q      <= '0;
        byte_idx_q <= '0;
        word_idx_q <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end else if (rx_ok && state_q == S_LEN) begin
        len_q      <= len_full;
        byte_idx_q <= byte_idx_q + 2'd1;
      end else if (rx_ok && state_q == S_DATA) begin
        asm_q      <= word_full;
        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_q     <= csum_q + rx_data;
`endif
        if (byte_last) begin
          mem_we     <= 1'b1;
          mem_addr   <= BASE_ADDR + word_idx_q[ADDR_WIDTH-1:0];
          mem_wdata  <= word_full;
          word_idx_q <= word_idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking bench for uart_loader (table vectors plus write scoreboard)
module tb_uart_loader;

  localparam int             AW   = 4;
  localparam logic [AW-1:0]  BASE = 4'hE;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_ok;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;

  uart_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_ok     (rx_ok),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] len;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_done;
    bit          exp_err;
    int          gap;
  } vec_t;

  vec_t               vecs[5];
  logic [7:0]         tx_q[$];
  logic [AW+31:0]     sb[$];
  logic [31:0]        wbuf[16];
  int                 pass_cnt  = 0;
  int                 total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every write the DUT makes must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (sb.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
      else check("write", {mem_addr, mem_wdata}, sb.pop_front());
    end
  end

  task automatic send_n(input int n, input int gap);
    for (int k = 0; k < n && tx_q.size() > 0; k++) begin
      @(posedge clk); #1;
      rx_ok   = 1'b1;
      rx_data = tx_q.pop_front();
      if (gap > 0) begin
        @(posedge clk); #1;
        rx_ok = 1'b0;
        repeat (gap - 1) @(posedge clk);
      end
    end
    @(posedge clk); #1;
    rx_ok = 1'b0;
  endtask

  task automatic flush_bytes(input int gap);
    send_n(tx_q.size(), gap);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic queue_frame(input logic [31:0] len, input int nw, input bit exp_w,
                             input logic [7:0] csum_delta);
    logic [7:0]    cs;
    logic [AW-1:0] a;
    cs = csum_delta;
    for (int b = 0; b < 4; b++) tx_q.push_back(len[8*b +: 8]);
    for (int i = 0; i < nw; i++) begin
      for (int b = 0; b < 4; b++) begin
        tx_q.push_back(wbuf[i][8*b +: 8]);
        cs = cs + wbuf[i][8*b +: 8];
      end
      a = BASE + AW'(i);
      if (exp_w) sb.push_back({a, wbuf[i]});
    end
`ifdef UART_LOADER_CHECKSUM_EN
    tx_q.push_back(cs);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    mem_we,    1'b0);
    check({tag, "_addr"},  mem_addr,  BASE);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_done"},  done,      1'b0);
    check({tag, "_error"}, error,     1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_ok = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Bytes in IDLE are ignored.
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    flush_bytes(0);
    @(negedge clk);
    check("idle_rx_busy", busy, 1'b0);
    check("idle_rx_done", done, 1'b0);

    vecs[0] = '{32'd2,     2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 0};
    vecs[1] = '{32'd17,    1, 32'h55555555, 32'h0,        1'b0, 1'b1, 1};
    vecs[2] = '{32'd0,     0, 32'h0,        32'h0,        1'b1, 1'b0, 2};
    vecs[3] = '{32'h100,   1, 32'h66666666, 32'h0,        1'b0, 1'b1, 0};
    vecs[4] = '{32'd1,     1, 32'hA5A5A5A5, 32'h0,        1'b1, 1'b0, 0};

    for (int i = 0; i < 5; i++) begin
      wbuf[0] = vecs[i].w0;
      wbuf[1] = vecs[i].w1;
      pulse_start();
      @(negedge clk);
      check($sformatf("v%0d_busy_after_start", i), busy, 1'b1);
      check($sformatf("v%0d_flags_cleared", i), {done, error}, 2'b00);
      queue_frame(vecs[i].len, vecs[i].nw, !vecs[i].exp_err, 8'h00);
      flush_bytes(vecs[i].gap);
      @(negedge clk);
      check($sformatf("v%0d_done", i),  done,  vecs[i].exp_done);
      check($sformatf("v%0d_error", i), error, vecs[i].exp_err);
      check($sformatf("v%0d_busy", i),  busy,  1'b0);
    end

    // Bytes in DONE are ignored.
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    flush_bytes(0);
    @(negedge clk);
    check("done_rx_done", done, 1'b1);
    check("done_rx_busy", busy, 1'b0);

    // start pulse mid-DATA is ignored.
    wbuf[0] = 32'hCAFEF00D;
    pulse_start();
    queue_frame(32'd1, 1, 1'b1, 8'h00);
    send_n(6, 0);
    pulse_start();
    @(negedge clk);
    check("mid_start_busy", busy, 1'b1);
    flush_bytes(0);
    @(negedge clk);
    check("mid_start_done", done, 1'b1);

    // Reset mid-word discards the partial word.
    wbuf[0] = 32'h11223344;
    pulse_start();
    queue_frame(32'd1, 1, 1'b0, 8'h00);
    send_n(6, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    tx_q = '{8'h33, 8'h44};
    flush_bytes(0);
    @(negedge clk);
    check("post_reset_busy", busy, 1'b0);

    // start and rx_ok together in IDLE: that byte is dropped.
    @(posedge clk); #1;
    start = 1'b1; rx_ok = 1'b1; rx_data = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0; rx_ok = 1'b0;
    wbuf[0] = 32'h0BADC0DE;
    queue_frame(32'd1, 1, 1'b1, 8'h00);
    flush_bytes(1);
    @(negedge clk);
    check("same_cycle_done", done, 1'b1);
    check("same_cycle_error", error, 1'b0);

    // Full capacity N = 2^AW with address wrap past the top.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h01010101 * i ^ 32'h5A3C0F00;
    pulse_start();
    queue_frame(32'd16, 16, 1'b1, 8'h00);
    flush_bytes(0);
    @(negedge clk);
    check("full_done", done, 1'b1);
    check("full_last_addr", mem_addr, 4'hD);

`ifdef UART_LOADER_CHECKSUM_EN
    wbuf[0] = 32'h04030201;
    pulse_start();
    queue_frame(32'd1, 1, 1'b1, 8'h00);
    flush_bytes(0);
    @(negedge clk);
    check("csum_good_done", done, 1'b1);
    pulse_start();
    queue_frame(32'd1, 1, 1'b1, 8'h01);
    flush_bytes(0);
    @(negedge clk);
    check("csum_bad_error", error, 1'b1);
    check("csum_bad_done", done, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader that sequences the UART receive path. It consumes the byte stream produced by the UART receiver (one `rx_ok` pulse per byte), parses a length-prefixed frame, assembles little-endian 32-bit words, and writes them into instruction/data memory. It then signals completion so the core can be released from its hold.

## Interface

Parameters:
- `ADDR_WIDTH`, default 14: word-address width of the target memory. Capacity is 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 0: word address of the first payload word. Width is ADDR_WIDTH.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  arms the loader. Honoured only in IDLE, DONE or ERROR.
- `rx_data`  in  8  received byte. Valid only while `rx_ok` is high.
- `rx_ok`  in  1  single-cycle pulse, one per received byte.
- `mem_we`  out  1  memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  word address for the write.
- `mem_wdata`  out  32  word to write.
- `busy`  out  1  high in LEN, DATA and CSUM.
- `done`  out  1  frame loaded successfully. Level signal.
- `error`  out  1  frame rejected. Level signal.

## Operation

- Frame format: 4-byte word count N (little-endian), then N×4 payload bytes. Each word is little-endian: the first byte goes to bits [7:0].
- States:
  - IDLE: `start` → LEN.
  - LEN: collect 4 bytes into a 32-bit count register. After the 4th byte:
    - N == 0 → DONE (or CSUM when the checksum is enabled).
    - N > 2^ADDR_WIDTH → ERROR.
    - Otherwise → DATA.
  - DATA: bytes are shifted into a 32-bit assembly register and counted by a 2-bit byte index. After the 4th byte of a word:
    - Issue a write at `BASE_ADDR + word_index`, then increment `word_index`.
    - When `word_index + 1 == N`: go to DONE (or CSUM) on the same edge.
  - CSUM: present only with the macro (see Configuration).
  - DONE / ERROR: hold until `start` (→ LEN, clearing `done`/`error`, count, indices and checksum) or reset.
- Address arithmetic is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. `BASE_ADDR + N` may wrap; wrapping is not an error.
- `rx_ok` in IDLE, DONE or ERROR is ignored: no state change, no write.
- `start` in LEN, DATA or CSUM is ignored.
- If `start` and `rx_ok` are high in the same cycle in IDLE, the byte is discarded. LEN begins on the next byte.

## Timing

- Reset values:
  - state IDLE
  - `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0
  - `busy`=0, `done`=0, `error`=0
  - all counters 0
- Reset mid-frame aborts immediately to IDLE. No further writes occur, and a partially assembled word is discarded.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - They become valid the cycle after the edge that samples the 4th `rx_ok` of a word.
  - `mem_we` stays high for exactly 1 cycle. `mem_addr`/`mem_wdata` hold until the next write.
- `done` and `error` rise on the cycle after the deciding byte's `rx_ok`. For the last word, `done` rises in the same cycle as its `mem_we`.
- `busy` is high from the cycle after `start` is accepted until the cycle `done` or `error` rises.
- Back-to-back `rx_ok` on consecutive cycles is supported with no byte loss. Throughput is one byte per cycle.

## Configuration

- Macro `UART_LOADER_CHECKSUM_EN`.
- Defined:
  - An 8-bit checksum accumulates the modulo-256 sum of all payload bytes. Length bytes are excluded.
  - After the last payload byte (or after LEN when N==0), the loader enters CSUM and waits for one more byte.
  - Byte equals the sum → DONE. Byte differs → ERROR.
  - Payload writes already issued are not undone.
- Undefined: no CSUM state and no checksum register. The frame ends after the last payload byte.

## Test plan

- Reset, then `start`, then bytes 02 00 00 00, 78 56 34 12, EF BE AD DE:
  - `mem_we` pulses twice: addr BASE_ADDR, data 0x12345678; then addr BASE_ADDR+1, data 0xDEADBEEF.
  - `done`=1, `busy`=0.
- Length 00 00 00 00: no `mem_we`. `done` rises one cycle after the 4th byte (without checksum).
- With ADDR_WIDTH=4, length 11 00 00 00 (17): `error`=1, no writes, later payload bytes ignored. A new `start` clears `error` and returns to LEN.
- Eight back-to-back `rx_ok` cycles forming length 1 plus word 0xA5A5A5A5, then `reset` asserted mid-stream in a second frame:
  - First frame: exactly one write.
  - After reset: all outputs return to reset values, and no write occurs for the partial word.
- With `UART_LOADER_CHECKSUM_EN`, length 1, payload 01 02 03 04:
  - Checksum byte 0x0A → `done`.
  - Repeated with 0x0B → `error`; word 0x04030201 was still written.
- `rx_ok` pulses in IDLE and in DONE, and `start` pulses during DATA: no state change, no writes, frame completes normally.
